// File: rtl/mdio_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_resp : Clause 22 MDIO responder with a 32 x 16 register file,       |
// |             oversampling MDC/MDIO on the system clock.                   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module mdio_resp #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter int          PRE_MIN  = 32,
  parameter bit          BCAST_EN = 1'b1,
  parameter logic [15:0] PHY_ID1  = 16'h001C,
  parameter logic [15:0] PHY_ID2  = 16'hC915
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [15:0] stat_i,
  output logic        wr_stb,
  output logic [4:0]  wr_reg,
  output logic [15:0] wr_data,
  output logic        rd_stb,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ST   = 3'd1,
    S_OP   = 3'd2,
    S_PHY  = 3'd3,
    S_REG  = 3'd4,
    S_TA   = 3'd5,
    S_DATA = 3'd6
  } state_t;

  logic mdc_s1_q, mdc_s2_q, mdc_s3_q;
  logic mdio_s1_q, mdio_s2_q;
  logic rise, bit_in;

  // Synchronisers run freely so that reset never fabricates an MDC edge.
  always_ff @(posedge clk) begin
    mdc_s1_q  <= mdc;
    mdc_s2_q  <= mdc_s1_q;
    mdc_s3_q  <= mdc_s2_q;
    mdio_s1_q <= mdio_i;
    mdio_s2_q <= mdio_s1_q;
  end

  assign rise   = mdc_s2_q & ~mdc_s3_q;
  assign bit_in = mdio_s2_q;

  state_t      state_q;
  logic [5:0]  pre_q;
  logic [3:0]  cnt_q;
  logic        rd_q, match_q;
  logic [15:0] sh_q, rdat_q;
  logic [4:0]  regad_q;
  logic        oe_q, o_q, wr_stb_q, rd_stb_q, busy_q;
  logic [4:0]  wr_reg_q;
  logic [15:0] wr_data_q;
  logic [15:0] regs_q [32];

  logic [15:0] sh_d, rdval_d;
  logic [4:0]  low5_d;
  logic        pre_ok_d, match_d;

  always_comb begin
    sh_d     = {sh_q[14:0], bit_in};
    low5_d   = sh_d[4:0];
    rdval_d  = regs_q[low5_d];
    if (low5_d == 5'd1) rdval_d = stat_i;
    if (low5_d == 5'd0) rdval_d[15] = 1'b0;
    pre_ok_d = (int'(pre_q) >= PRE_MIN);
    match_d  = (low5_d == PHY_ADDR) ||
               ((BCAST_EN != 1'b0) && (low5_d == 5'd0) && !rd_q);
  end

  function automatic logic [15:0] dflt(input int idx);
    case (idx)
      0:       dflt = 16'h1140;
      2:       dflt = PHY_ID1;
      3:       dflt = PHY_ID2;
      default: dflt = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      match_q   <= 1'b0;
      sh_q      <= '0;
      rdat_q    <= '0;
      regad_q   <= '0;
      oe_q      <= 1'b0;
      o_q       <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= dflt(i);
    end else begin
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      if (rise) begin
        case (state_q)
          S_IDLE: begin
            if (bit_in) begin
              if (pre_q != 6'h3F) pre_q <= pre_q + 6'd1;
            end else begin
              pre_q <= '0;
              if (pre_ok_d) state_q <= S_ST;
            end
          end
          S_ST: begin
            if (bit_in) begin
              state_q <= S_OP;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_OP: begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd1) begin
              cnt_q <= '0;
              if (sh_d[1:0] == 2'b10) begin
                rd_q    <= 1'b1;
                state_q <= S_PHY;
              end else if (sh_d[1:0] == 2'b01) begin
                rd_q    <= 1'b0;
                state_q <= S_PHY;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          S_PHY: begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd4) begin
              cnt_q   <= '0;
              match_q <= match_d;
              state_q <= S_REG;
            end
          end
          S_REG: begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd4) begin
              cnt_q   <= '0;
              regad_q <= low5_d;
              rdat_q  <= rdval_d;
              state_q <= S_TA;
            end
          end
          S_TA: begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd0) begin
              // Drive the second turnaround bit low.
              if (rd_q && match_q) begin
                oe_q <= 1'b1;
                o_q  <= 1'b0;
              end
            end else begin
              cnt_q <= '0;
              if (rd_q) begin
                state_q <= S_DATA;
                if (match_q) begin
                  o_q    <= rdat_q[15];
                  rdat_q <= {rdat_q[14:0], 1'b0};
                end
              end else if (bit_in) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q != 4'd15) begin
              if (rd_q && match_q) begin
                o_q    <= rdat_q[15];
                rdat_q <= {rdat_q[14:0], 1'b0};
              end
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              oe_q    <= 1'b0;
              o_q     <= 1'b0;
              cnt_q   <= '0;
              pre_q   <= '0;
              if (rd_q) begin
                rd_stb_q <= match_q;
              end else if (match_q) begin
                wr_stb_q  <= 1'b1;
                wr_reg_q  <= regad_q;
                wr_data_q <= sh_d;
                if ((regad_q == 5'd0) && sh_d[15]) begin
                  for (int i = 0; i < 32; i++) regs_q[i] <= dflt(i);
                end else if ((regad_q == 5'd0) || (regad_q > 5'd3)) begin
                  regs_q[regad_q] <= sh_d;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Reset releases the line combinationally, not one clock later.
  assign mdio_oe = oe_q & ~rst;
  assign mdio_o  = o_q;
  assign wr_stb  = wr_stb_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign rd_stb  = rd_stb_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdio_resp : directed MDIO frames against a register-file model.       |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_mdio_resp;

  localparam logic [4:0]  PHY_ADDR = 5'd1;
  localparam int          PRE_MIN  = 32;
  localparam logic [15:0] PHY_ID1  = 16'h001C;
  localparam logic [15:0] PHY_ID2  = 16'hC915;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b0;
  logic        m_o = 1'b1;
  logic        m_oe = 1'b0;
  logic [15:0] stat_i = 16'h7809;
  logic        mdio_line, mdio_o, mdio_oe, wr_stb, rd_stb, busy;
  logic [4:0]  wr_reg;
  logic [15:0] wr_data;

  // Open-drain style bus with a pull-up.
  assign mdio_line = mdio_oe ? mdio_o : (m_oe ? m_o : 1'b1);

  mdio_resp #(
    .PHY_ADDR(PHY_ADDR), .PRE_MIN(PRE_MIN), .BCAST_EN(1'b1),
    .PHY_ID1(PHY_ID1), .PHY_ID2(PHY_ID2)
  ) dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_line),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .stat_i(stat_i),
    .wr_stb(wr_stb), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_stb(rd_stb), .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   wr_pulses = 0;
  int   rd_pulses = 0;
  logic chk = 1'b0, exp_oe = 1'b0, exp_o = 1'b0, exp_busy = 1'b0;
  logic [15:0] m_reg [32];

  // Per-cycle comparison while MDC is low, where outputs are settled.
  always @(posedge clk) begin
    #1;
    if (wr_stb) wr_pulses++;
    if (rd_stb) rd_pulses++;
    if (chk && !mdc) begin
      checks++;
      if (mdio_oe !== exp_oe) begin
        errors++;
        $display("FAIL mdio_oe t=%0t got %b exp %b", $time, mdio_oe, exp_oe);
      end
      if (exp_oe) begin
        checks++;
        if (mdio_o !== exp_o) begin
          errors++;
          $display("FAIL mdio_o t=%0t got %b exp %b", $time, mdio_o, exp_o);
        end
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy t=%0t got %b exp %b", $time, busy, exp_busy);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 16'h0000;
    m_reg[0] = 16'h1140;
    m_reg[2] = PHY_ID1;
    m_reg[3] = PHY_ID2;
  endfunction

  function automatic void model_write(input logic [4:0] ra, input logic [15:0] d);
    if (ra == 5'd0 && d[15]) model_reset();
    else if (!(ra inside {5'd1, 5'd2, 5'd3})) m_reg[ra] = d;
  endfunction

  function automatic logic [15:0] model_read(input logic [4:0] ra);
    return (ra == 5'd1) ? stat_i : m_reg[ra];
  endfunction

  // One MDC period: master drives on the fall, samples just before the rise.
  task automatic slot(input logic drv, input logic val, input logic eo,
                      input logic eov, input logic eb, output logic seen);
    @(negedge clk);
    mdc = 1'b0; m_oe = drv; m_o = val;
    exp_oe = eo; exp_o = eov; exp_busy = eb; chk = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    seen = mdio_line;
    mdc = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                       input int rst_j, output logic [15:0] got);
    logic        starts, is_rd, is_wr, matched, ta_ok, served_rd, do_wr, s;
    logic        drv, eoe, eo, eb;
    logic [15:0] rdat;
    logic [31:0] fb;
    int          busy_end, wr0, rd0;
    starts    = (pre >= PRE_MIN);
    is_rd     = (op == 2'b10);
    is_wr     = (op == 2'b01);
    matched   = (phy == PHY_ADDR) || (phy == 5'd0 && is_wr);
    ta_ok     = !is_wr || (ta[0] == 1'b0);
    busy_end  = !(is_rd || is_wr) ? 3 : (!ta_ok ? 15 : 31);
    served_rd = starts && is_rd && matched;
    do_wr     = starts && is_wr && ta_ok && matched;
    rdat      = model_read(ra);
    fb        = {2'b01, op, phy, ra, ta, wd};
    wr0 = wr_pulses; rd0 = rd_pulses; got = 16'h0000;
    for (int i = 0; i < pre; i++) slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, s);
    for (int j = 0; j < 32; j++) begin
      drv = !(is_rd && j >= 14);
      eoe = served_rd && j >= 15;
      eo  = (j >= 16) ? rdat[31-j] : 1'b0;
      eb  = starts && j >= 2 && j <= busy_end;
      if (is_rd && j == 20) stat_i = ~stat_i;
      if (j == rst_j) begin
        @(negedge clk);
        mdc = 1'b0; m_oe = 1'b0;
        exp_oe = eoe; exp_o = eo; exp_busy = eb; chk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; exp_oe = 1'b0; exp_busy = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_oe", {31'd0, mdio_oe}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk = 1'b0;
        model_reset();
        return;
      end
      slot(drv, fb[31-j], eoe, eo, eb, s);
      if (j >= 16) got = {got[14:0], s};
    end
    slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, s);
    slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s);
    chk = 1'b0;
    if (do_wr) model_write(ra, wd);
    check("wr_stb_count", wr_pulses - wr0, do_wr ? 32'd1 : 32'd0);
    check("rd_stb_count", rd_pulses - rd0, served_rd ? 32'd1 : 32'd0);
    if (do_wr) begin
      check("wr_reg", {27'd0, wr_reg}, {27'd0, ra});
      check("wr_data", {16'd0, wr_data}, {16'd0, wd});
    end
    if (served_rd) check("rd_data_model", {16'd0, got}, {16'd0, rdat});
  endtask

  logic [15:0] got;

  initial begin
    model_reset();
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check("rst_oe_during", {31'd0, mdio_oe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_outputs", {mdio_oe, mdio_o, busy, wr_stb, rd_stb, wr_reg, wr_data}, 32'd0);

    frame(32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0, -1, got);
    check("rd_reg2_id1", {16'd0, got}, 32'h001C);

    frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'h01E1, -1, got);
    check("wr_reg4_data", {16'd0, wr_data}, 32'h01E1);
    frame(32, 2'b10, 5'd1, 5'd4, 2'b10, 16'h0, -1, got);
    check("rd_reg4_01E1", {16'd0, got}, 32'h01E1);

    frame(31, 2'b01, 5'd1, 5'd4, 2'b10, 16'hFFFF, -1, got);
    frame(32, 2'b11, 5'd1, 5'd4, 2'b10, 16'hFFFF, -1, got);
    frame(32, 2'b01, 5'd5, 5'd4, 2'b10, 16'hFFFF, -1, got);
    frame(32, 2'b10, 5'd5, 5'd4, 2'b10, 16'h0, -1, got);
    check("rd_phy5_float", {16'd0, got}, 32'hFFFF);
    frame(32, 2'b01, 5'd1, 5'd4, 2'b11, 16'hFFFF, -1, got);
    frame(32, 2'b10, 5'd1, 5'd4, 2'b10, 16'h0, -1, got);
    check("rd_reg4_kept", {16'd0, got}, 32'h01E1);

    frame(32, 2'b10, 5'd1, 5'd1, 2'b10, 16'h0, -1, got);
    check("rd_reg1_stat", {16'd0, got}, 32'h7809);
    frame(32, 2'b10, 5'd1, 5'd0, 2'b10, 16'h0, -1, got);
    check("rd_reg0_dflt", {16'd0, got}, 32'h1140);

    frame(32, 2'b01, 5'd0, 5'd4, 2'b10, 16'hAAAA, -1, got);
    frame(32, 2'b10, 5'd0, 5'd4, 2'b10, 16'h0, -1, got);
    check("rd_bcast_float", {16'd0, got}, 32'hFFFF);
    frame(32, 2'b10, 5'd1, 5'd4, 2'b10, 16'h0, -1, got);
    check("rd_reg4_AAAA", {16'd0, got}, 32'hAAAA);

    frame(32, 2'b01, 5'd1, 5'd3, 2'b10, 16'h1234, -1, got);
    frame(32, 2'b10, 5'd1, 5'd3, 2'b10, 16'h0, -1, got);
    check("rd_reg3_ro", {16'd0, got}, 32'hC915);

    frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h8000, -1, got);
    frame(32, 2'b10, 5'd1, 5'd4, 2'b10, 16'h0, -1, got);
    check("rd_reg4_cleared", {16'd0, got}, 32'h0000);
    frame(32, 2'b10, 5'd1, 5'd0, 2'b10, 16'h0, -1, got);
    check("rd_reg0_restored", {16'd0, got}, 32'h1140);

    frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'h5555, -1, got);
    frame(32, 2'b10, 5'd1, 5'd4, 2'b10, 16'h0, 24, got);
    frame(32, 2'b10, 5'd1, 5'd4, 2'b10, 16'h0, -1, got);
    check("rd_after_rst", {16'd0, got}, 32'h0000);
    frame(32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0, -1, got);
    check("rd_reg2_after_rst", {16'd0, got}, 32'h001C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
